aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
Sequencer for an iterative AES-128 round datapath: one round per clock, key schedule computed on the fly. Accepts encrypt/decrypt requests on a valid/ready handshake. Drives the datapath's load, AddRoundKey, key-step and round strobes plus the round constant. Raises a result handshake when the block is finished. Sits between the top-level AES wrapper and a shared round/key-expansion datapath that holds no control of its own.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) supported.
DEC_EN, 1, 1 = decrypt supported; 0 = req_decrypt ignored and every request treated as encrypt.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present; datapath block/key inputs valid
req_decrypt  in  1  1 = decrypt, sampled on accept
req_ready  out  1  controller idle, can accept
done_valid  out  1  datapath state register holds the result
done_ready  in  1  consumer takes the result
done_decrypt  out  1  operation type of the current result
busy  out  1  not IDLE
dp_load  out  1  datapath captures block and cipher key (key0)
dp_ark  out  1  XOR current round key into state; with dp_load, XOR applies to the incoming block
dp_key_fwd  out  1  key register steps forward one round using dp_rcon
dp_key_inv  out  1  key register steps back one round using dp_rcon
dp_round  out  1  apply one round (inverse round if done_decrypt) using the key produced by the same-cycle key step
dp_final  out  1  qualifies dp_round: omit (Inv)MixColumns
dp_rcon  out  8  round constant for the current key step
dp_round_idx  out  4  1..10 during rounds, else 0

Behaviour:
- Reset: state IDLE, rcon register 8'h01, counter 0. All outputs 0 except req_ready=1.
- Reset is honoured in any state and abandons the operation mid-flight; no done_valid is produced for it.
- Accept = req_valid & req_ready. req_ready=1 only in IDLE. req_valid in other states is ignored, not queued.
- FSM states: IDLE, KEYFWD, ARK, ROUND, DONE.
- IDLE:
  - On accept, dp_load=1 in the same cycle; latch the op type.
  - Encrypt: dp_ark=1 in that cycle, go to ROUND with rcon=01.
  - Decrypt: dp_ark=0, go to KEYFWD with rcon=01.
- KEYFWD (decrypt only): 10 cycles, dp_key_fwd=1, rcon 01..36. After the 10th cycle the key register holds key10; go to ARK.
- ARK: one cycle, dp_ark=1. rcon register set to 36; go to ROUND.
- ROUND: 10 cycles, dp_round=1, dp_round_idx=1..10, dp_final=1 only when idx=10.
  - Encrypt: dp_key_fwd=1, rcon sequence 01,02,04,08,10,20,40,80,1b,36.
  - Decrypt: dp_key_inv=1, rcon sequence 36,1b,80,40,20,10,08,04,02,01.
  - After idx 10, go to DONE.
- rcon update:
  - Forward: xtime, (r<<1) ^ (r[7] ? 1b : 00).
  - Inverse: r[0] ? ((r^1b)>>1)|80 : r>>1.
- DONE: done_valid=1, held with done_decrypt stable until done_ready. On the handshake cycle go to IDLE; req_ready=1 the following cycle. done_ready while done_valid=0 has no effect.
- Exactly one of dp_key_fwd / dp_key_inv / none per cycle. dp_load is never asserted outside an accept cycle.
- Latency, accept cycle = 0:
  - Encrypt: rounds in cycles 1..10, done_valid from cycle 11.
  - Decrypt: KEYFWD 1..10, ARK 11, rounds 12..21, done_valid from cycle 22.
- Counter is 4 bits. Wrap is impossible because the FSM exits at 10.

Decomposition:
- Package aes_ctrl_pkg: state enum, NR=10, RCON_INIT=8'h01, RCON_LAST=8'h36, RCON_POLY=8'h1b, functions rcon_fwd/rcon_inv.
- One sub-module, aes_rcon_gen: clk, rst, load_init, load_last, step_fwd, step_inv, rcon[7:0].

Test Plan:
- Encrypt, done_ready=1: accept at cycle 0 -> dp_load&dp_ark at 0; dp_rcon 01,02,04,08,10,20,40,80,1b,36 in cycles 1..10; dp_final only at cycle 10; done_valid at 11; req_ready at 12.
- Decrypt: accept at 0 -> dp_key_fwd cycles 1..10 with rcon 01..36; dp_ark at 11; dp_key_inv cycles 12..21 with rcon 36,1b,80,40,20,10,08,04,02,01; done_valid at 22 with done_decrypt=1.
- Backpressure: done_ready low for 5 cycles after done_valid -> done_valid and done_decrypt held, req_ready=0; a req_valid pulse in this window is ignored (no dp_load).
- Reset mid-op: rst at ROUND idx 4 -> next cycle all strobes 0, req_ready=1, dp_rcon=01; a new encrypt request then completes normally.
- DEC_EN=0, req_decrypt=1 -> encrypt timing, done_decrypt=0.
- Integration with the round datapath, FIPS-197 C.1:
  - Encrypt key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Decrypt of that ciphertext returns the plaintext.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared types, constants and round-constant helpers for the AES-128 round sequencer.
// Pure definitions: no state, no latency, no flow control.
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYFWD,
        ST_ARK,
        ST_ROUND,
        ST_DONE
    } state_t;

    localparam int         NR        = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_LAST = 8'h36;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    function automatic logic [7:0] rcon_fwd(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? RCON_POLY : 8'h00);
    endfunction

    // Undoes xtime: an odd value means the reduction polynomial was folded in.
    function automatic logic [7:0] rcon_inv(input logic [7:0] r);
        return r[0] ? (((r ^ RCON_POLY) >> 1) | 8'h80) : (r >> 1);
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Request/result handshake between the AES wrapper (master) and the round sequencer (slave).
// Valid/ready on both directions; the master must hold request fields until accepted.
interface aes_round_ctrl_if;
    logic req_valid;
    logic req_decrypt;
    logic req_ready;
    logic done_valid;
    logic done_ready;
    logic done_decrypt;

    modport master (
        output req_valid, req_decrypt, done_ready,
        input  req_ready, done_valid, done_decrypt
    );

    modport slave (
        input  req_valid, req_decrypt, done_ready,
        output req_ready, done_valid, done_decrypt
    );
endinterface

// File: rtl/aes_rcon_gen.sv
// Round-constant register, steppable forward (xtime) or backward; new value visible next cycle.
// No flow control: load_init wins over load_last, which wins over any step.
module aes_rcon_gen
    import aes_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_init,
    input  logic       load_last,
    input  logic       step_fwd,
    input  logic       step_inv,
    output logic [7:0] rcon
);

    logic [7:0] r_rcon;

    always_ff @(posedge clk) begin
        if (rst || load_init) begin
            r_rcon <= RCON_INIT;
        end else if (load_last) begin
            r_rcon <= RCON_LAST;
        end else if (step_fwd) begin
            r_rcon <= rcon_fwd(r_rcon);
        end else if (step_inv) begin
            r_rcon <= rcon_inv(r_rcon);
        end
    end

    assign rcon = r_rcon;

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for an iterative AES-128 datapath: encrypt result after 11 cycles, decrypt after 22.
// One request in flight; req_ready only in IDLE, result held in DONE until done_ready.
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NR     = aes_ctrl_pkg::NR,
    parameter bit DEC_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    aes_round_ctrl_if.slave  ctrl_if,
    output logic             busy,
    output logic             dp_load,
    output logic             dp_ark,
    output logic             dp_key_fwd,
    output logic             dp_key_inv,
    output logic             dp_round,
    output logic             dp_final,
    output logic [7:0]       dp_rcon,
    output logic [3:0]       dp_round_idx
);

    localparam logic [3:0] LP_NR = 4'(NR);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [3:0] r_idx;
    logic       r_dec;
    logic       r_req_ready;
    logic       r_busy;
    logic       r_done_valid;
    logic       r_key_fwd;
    logic       r_key_inv;
    logic       r_round;
    logic       r_final;
    logic       r_ark;

    logic       w_dec;
    logic       w_accept;
    logic       w_last;
    logic       w_rcon_init;
    logic       w_rcon_last;

    assign w_dec    = DEC_EN & ctrl_if.req_decrypt;
    assign w_accept = ctrl_if.req_valid & r_req_ready & ~rst;
    assign w_last   = (r_cnt == LP_NR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_idx        <= 4'd0;
            r_dec        <= 1'b0;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_done_valid <= 1'b0;
            r_key_fwd    <= 1'b0;
            r_key_inv    <= 1'b0;
            r_round      <= 1'b0;
            r_final      <= 1'b0;
            r_ark        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_dec       <= w_dec;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cnt       <= 4'd1;
                        r_key_fwd   <= 1'b1;
                        if (w_dec) begin
                            r_state <= ST_KEYFWD;
                        end else begin
                            r_state <= ST_ROUND;
                            r_round <= 1'b1;
                            r_idx   <= 4'd1;
                        end
                    end
                end
                ST_KEYFWD: begin
                    // Walk the key schedule up to key10 before the inverse rounds.
                    if (w_last) begin
                        r_state   <= ST_ARK;
                        r_key_fwd <= 1'b0;
                        r_ark     <= 1'b1;
                        r_cnt     <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_ARK: begin
                    r_state   <= ST_ROUND;
                    r_ark     <= 1'b0;
                    r_round   <= 1'b1;
                    r_idx     <= 4'd1;
                    r_cnt     <= 4'd1;
                    r_key_inv <= 1'b1;
                end
                ST_ROUND: begin
                    if (w_last) begin
                        r_state      <= ST_DONE;
                        r_round      <= 1'b0;
                        r_final      <= 1'b0;
                        r_key_fwd    <= 1'b0;
                        r_key_inv    <= 1'b0;
                        r_idx        <= 4'd0;
                        r_cnt        <= 4'd0;
                        r_done_valid <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + 4'd1;
                        r_idx   <= r_cnt + 4'd1;
                        r_final <= (r_cnt == LP_NR - 4'd1);
                    end
                end
                ST_DONE: begin
                    if (ctrl_if.done_ready) begin
                        r_state      <= ST_IDLE;
                        r_done_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Re-arm rcon on the last round so IDLE always shows the initial constant.
    assign w_rcon_init = w_accept | ((r_state == ST_ROUND) & w_last);
    assign w_rcon_last = (r_state == ST_ARK);

    aes_rcon_gen u_rcon (
        .clk       (clk),
        .rst       (rst),
        .load_init (w_rcon_init),
        .load_last (w_rcon_last),
        .step_fwd  (r_key_fwd),
        .step_inv  (r_key_inv),
        .rcon      (dp_rcon)
    );

    assign ctrl_if.req_ready    = r_req_ready;
    assign ctrl_if.done_valid   = r_done_valid;
    assign ctrl_if.done_decrypt = r_dec;

    assign busy         = r_busy;
    assign dp_load      = w_accept;
    assign dp_ark       = (w_accept & ~w_dec) | r_ark;
    assign dp_key_fwd   = r_key_fwd;
    assign dp_key_inv   = r_key_inv;
    assign dp_round     = r_round;
    assign dp_final     = r_final;
    assign dp_round_idx = r_idx;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: random traffic on a decrypt-capable and an encrypt-only instance,
// checked cycle by cycle against a cycle-offset model, plus a FIPS-197 round trip.
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, t_req_valid, t_req_decrypt, t_done_ready;

    aes_round_ctrl_if if0();
    aes_round_ctrl_if if1();

    assign if0.req_valid   = t_req_valid;
    assign if0.req_decrypt = t_req_decrypt;
    assign if0.done_ready  = t_done_ready;
    assign if1.req_valid   = t_req_valid;
    assign if1.req_decrypt = t_req_decrypt;
    assign if1.done_ready  = t_done_ready;

    logic       busy0, load0, ark0, kf0, ki0, rnd0, fin0;
    logic [7:0] rc0;
    logic [3:0] idx0;
    logic       busy1, load1, ark1, kf1, ki1, rnd1, fin1;
    logic [7:0] rc1;
    logic [3:0] idx1;

    aes_round_ctrl #(.NR(10), .DEC_EN(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .ctrl_if(if0), .busy(busy0),
        .dp_load(load0), .dp_ark(ark0), .dp_key_fwd(kf0), .dp_key_inv(ki0),
        .dp_round(rnd0), .dp_final(fin0), .dp_rcon(rc0), .dp_round_idx(idx0)
    );

    aes_round_ctrl #(.NR(10), .DEC_EN(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .ctrl_if(if1), .busy(busy1),
        .dp_load(load1), .dp_ark(ark1), .dp_key_fwd(kf1), .dp_key_inv(ki1),
        .dp_round(rnd1), .dp_final(fin1), .dp_rcon(rc1), .dp_round_idx(idx1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    localparam logic [7:0] RC_TAB [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    // ---------------- controller reference: outputs as a function of cycles since accept
    bit m_act [2];
    bit m_dec [2];
    int m_k   [2];
    bit m_rst_seen [2];

    task automatic check_inst(input int i);
        logic [12:0] got, exp;
        logic [7:0]  got_rc;
        logic        got_dd;
        logic [7:0]  exp_rc = 8'h01;
        bit rc_valid;
        bit dec_eff;
        bit rr = 0, bz = 0, dv = 0, ld = 0, ak = 0, kf = 0, ki = 0, rd = 0, fn = 0;
        logic [3:0] ix = 4'd0;
        int k, lat;
        if (i == 0) begin
            got    = {if0.req_ready, busy0, if0.done_valid, load0, ark0, kf0, ki0, rnd0, fin0, idx0};
            got_rc = rc0;
            got_dd = if0.done_decrypt;
        end else begin
            got    = {if1.req_ready, busy1, if1.done_valid, load1, ark1, kf1, ki1, rnd1, fin1, idx1};
            got_rc = rc1;
            got_dd = if1.done_decrypt;
        end
        dec_eff  = (i == 0) ? t_req_decrypt : 1'b0;
        rc_valid = m_rst_seen[i];
        if (!m_act[i]) begin
            rr = 1;
            ld = t_req_valid;
            ak = t_req_valid & ~dec_eff;
        end else begin
            bz  = 1;
            k   = m_k[i];
            lat = m_dec[i] ? 22 : 11;
            if (k >= lat) begin
                dv = 1;
            end else if (!m_dec[i]) begin
                rd = 1; kf = 1; ix = 4'(k); fn = (k == 10);
                rc_valid = 1; exp_rc = RC_TAB[k-1];
            end else if (k <= 10) begin
                kf = 1; rc_valid = 1; exp_rc = RC_TAB[k-1];
            end else if (k == 11) begin
                ak = 1;
            end else begin
                rd = 1; ki = 1; ix = 4'(k - 11); fn = (k == 21);
                rc_valid = 1; exp_rc = RC_TAB[21-k];
            end
            chk($sformatf("done_dec%0d", i), got_dd, m_dec[i]);
        end
        exp = {rr, bz, dv, ld, ak, kf, ki, rd, fn, ix};
        chk($sformatf("ctrl%0d", i), got, exp);
        if (rc_valid) chk($sformatf("rcon%0d", i), got_rc, exp_rc);
    endtask

    task automatic advance(input int i);
        bit dec_eff;
        dec_eff = (i == 0) ? t_req_decrypt : 1'b0;
        m_rst_seen[i] = 0;
        if (rst) begin
            m_act[i] = 0;
            m_rst_seen[i] = 1;
        end else if (!m_act[i]) begin
            if (t_req_valid) begin
                m_act[i] = 1; m_dec[i] = dec_eff; m_k[i] = 1;
            end
        end else if (m_k[i] >= (m_dec[i] ? 22 : 11) && t_done_ready) begin
            m_act[i] = 0;
        end else begin
            m_k[i]++;
        end
    endtask

    task automatic run_cycle(input bit r, input bit rv, input bit rdec, input bit drdy);
        @(negedge clk);
        rst = r; t_req_valid = rv; t_req_decrypt = rdec; t_done_ready = drdy;
        #1;
        check_inst(0);
        check_inst(1);
        @(posedge clk);
        advance(0);
        advance(1);
    endtask

    // ---------------- behavioural AES-128 datapath driven by instance 0's strobes
    logic [7:0]   sbox [256];
    logic [7:0]   isbox [256];
    logic [127:0] dp_blk_in, dp_key_in, dpm_state, dpm_key;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int j = 0; j < 8; j++) begin
            if (b[j]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endtask

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv ? isbox[gb(s, i)] : sbox[gb(s, i)];
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] r;
        int src;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) begin
                src = inv ? (c - w + 4) % 4 : (c + w) % 4;
                r[127-8*(c*4+w) -: 8] = gb(s, src*4 + w);
            end
        return r;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
        logic [127:0] r;
        logic [7:0] m [4];
        logic [7:0] b;
        if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
        else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++) b ^= gmul(gb(s, c*4+k), m[(k - w + 4) % 4]);
                r[127-8*(c*4+w) -: 8] = b;
            end
        return r;
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        logic [31:0] t;
        t = {w[23:0], w[31:24]};
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic f,
                                              input logic iv, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        if (f) begin
            w0 = w0 ^ sub_rot(w3) ^ {rc, 24'h0};
            w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        end else if (iv) begin
            w3 = w3 ^ w2; w2 = w2 ^ w1; w1 = w1 ^ w0;
            w0 = w0 ^ sub_rot(w3) ^ {rc, 24'h0};
        end
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic dec, input logic fin);
        logic [127:0] t;
        if (!dec) begin
            t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
            if (!fin) t = mix_cols(t, 1'b0);
            return t ^ k;
        end
        t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
        if (!fin) t = mix_cols(t, 1'b1);
        return t;
    endfunction

    always @(posedge clk) begin
        if (load0) begin
            dpm_key   <= dp_key_in;
            dpm_state <= ark0 ? (dp_blk_in ^ dp_key_in) : dp_blk_in;
        end else begin
            dpm_key <= next_key(dpm_key, kf0, ki0, rc0);
            if (ark0)
                dpm_state <= dpm_state ^ dpm_key;
            else if (rnd0)
                dpm_state <= aes_round(dpm_state, next_key(dpm_key, kf0, ki0, rc0),
                                       if0.done_decrypt, fin0);
        end
    end

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        bit mid_rst_done = 0;
        bit r;
        build_sbox();
        dp_blk_in = '0; dp_key_in = '0;
        rst = 1'b1; t_req_valid = 1'b0; t_req_decrypt = 1'b0; t_done_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin m_act[i] = 0; m_rst_seen[i] = 1; end
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 299) == 0);
            // Make sure an encrypt is abandoned at round 4 at least once.
            if (!mid_rst_done && m_act[0] && !m_dec[0] && m_k[0] == 4) begin
                r = 1'b1;
                mid_rst_done = 1;
            end
            run_cycle(r, r ? 1'b0 : ($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
        end

        for (int n = 0; n < 100 && m_act[0]; n++) run_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("drain_timeout", m_act[0], 1'b0);

        dp_key_in = KEY;
        dp_blk_in = PT;
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (10) run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("fips_enc", dpm_state, CT);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1);

        dp_blk_in = CT;
        run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (21) run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("fips_dec", dpm_state, PT);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
